// File: rtl/i2s_tx_if.sv
// Sample-pair handshake between an audio source and the I2S transmitter.
// The master drives a left/right pair with valid; the slave returns ready.
interface i2s_tx_if;
   localparam int unsigned SAMPLE_W = 16;

   logic [SAMPLE_W-1:0] sample_l;
   logic [SAMPLE_W-1:0] sample_r;
   logic                sample_valid;
   logic                sample_ready;

   modport master (
      output sample_l,
      output sample_r,
      output sample_valid,
      input  sample_ready
   );

   modport slave (
      input  sample_l,
      input  sample_r,
      input  sample_valid,
      output sample_ready
   );
endinterface

// File: rtl/i2s_tx.sv
// Philips-format I2S master transmitter with a single-pair holding buffer.
// BCLK, WS and DATA all come from clk_sys through an integer divider.
module i2s_tx #(
   parameter int unsigned CLK_DIV = 8,
   parameter int unsigned WIDTH   = 16
) (
   input  logic     clk_sys,
   input  logic     RESET,
   input  logic     en,
   i2s_tx_if.slave  smp,
   output logic     i2s_bclk,
   output logic     i2s_ws,
   output logic     i2s_data,
   output logic     underrun
);
   localparam int unsigned FRAME_W = 2 * WIDTH;
   localparam int unsigned SLOT_W  = 5;
   localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   logic [DIV_W-1:0]   div_cnt;
   logic [SLOT_W-1:0]  slot;
   logic [FRAME_W-1:0] shreg;
   logic [WIDTH-1:0]   buf_l;
   logic [WIDTH-1:0]   buf_r;
   logic               buf_full;
   logic               ready_q;

   logic               accept;
   logic               div_wrap;
   logic               tick;
   logic [SLOT_W-1:0]  slot_nxt;
   logic               frame_load;

   // Data is the shift-register MSB, so the slot-0 load is visible the same cycle.
   assign i2s_data         = shreg[FRAME_W-1];
   assign smp.sample_ready = ready_q;

   // Divider wrap, falling-edge tick and frame-start detection.
   always_comb begin
      accept     = smp.sample_valid & ready_q;
      div_wrap   = (div_cnt == DIV_W'(CLK_DIV - 1));
      tick       = div_wrap & i2s_bclk;
      slot_nxt   = slot + SLOT_W'(1);
      frame_load = tick & (slot_nxt == '0);
   end

   always_ff @(posedge clk_sys) begin
      if (RESET) begin
         div_cnt  <= '0;
         slot     <= '1;
         shreg    <= '0;
         i2s_bclk <= 1'b0;
         i2s_ws   <= 1'b0;
         underrun <= 1'b0;
         buf_l    <= '0;
         buf_r    <= '0;
         buf_full <= 1'b0;
         ready_q  <= 1'b1;
      end else begin
         // Holding buffer: accept only while empty, drained by a frame load.
         if (accept) begin
            buf_l    <= smp.sample_l;
            buf_r    <= smp.sample_r;
            buf_full <= 1'b1;
            ready_q  <= 1'b0;
         end else if (en && frame_load && buf_full) begin
            buf_full <= 1'b0;
            ready_q  <= 1'b1;
         end

         underrun <= 1'b0;

         if (!en) begin
            div_cnt  <= '0;
            slot     <= '1;
            shreg    <= '0;
            i2s_bclk <= 1'b0;
            i2s_ws   <= 1'b0;
         end else begin
            div_cnt <= div_wrap ? '0 : div_cnt + DIV_W'(1);
            if (div_wrap) begin
               i2s_bclk <= ~i2s_bclk;
            end
            if (tick) begin
               slot   <= slot_nxt;
               // WS leads each channel MSB by one bit clock.
               i2s_ws <= (slot_nxt >= SLOT_W'(15)) && (slot_nxt != SLOT_W'(31));
               if (frame_load) begin
                  if (buf_full) begin
                     shreg <= {buf_l, buf_r};
                  end else begin
                     shreg    <= '0;
                     underrun <= 1'b1;
                  end
               end else begin
                  shreg <= {shreg[FRAME_W-2:0], 1'b0};
               end
            end
         end
      end
   end
endmodule

// File: doc/i2s_tx.md
Name: i2s_tx

Overview:
- I2S master transmitter: the sending end of the codebase's MT32-pi style I2S audio link.
- Accepts 16-bit signed left/right sample pairs from core logic through a valid/ready handshake.
- Generates BCLK, WS and DATA in Philips I2S format, all derived from clk_sys by an integer divider.
- Sits between a core's audio mixer and the USER_OUT pins; the existing I2S receiver can be used as a loopback checker.

Parameters:
- CLK_DIV, 8: clk_sys cycles per BCLK half-period (≥1). Frame rate = f_clk_sys / (2 * CLK_DIV * 32).
- WIDTH, 16: bits per channel. Fixed at 16 for this revision; 32 BCLK per frame.

Ports:
- clk_sys  in  1  system clock
- RESET  in  1  synchronous reset, active-high
- en  in  1  1 = run; 0 = hold outputs idle (same state as reset), handshake still works
- sample_l  in  16  left sample, two's complement
- sample_r  in  16  right sample
- sample_valid  in  1  pair presented
- sample_ready  out  1  holding buffer empty; a pair is accepted when valid & ready
- i2s_bclk  out  1  bit clock
- i2s_ws  out  1  word select, 0 = left, 1 = right
- i2s_data  out  1  serial data, MSB first
- underrun  out  1  one-cycle pulse when a frame starts with no buffered pair

Behaviour:
- **Reset** (RESET=1, or en=0):
  - i2s_bclk=0, i2s_ws=0, i2s_data=0, underrun=0.
  - div_cnt=0, slot=31, shift register=0.
  - RESET additionally empties the buffer, so sample_ready=1 the cycle after RESET deasserts.
  - RESET mid-frame aborts the frame immediately; there is no completion.
- **Divider**:
  - div_cnt counts 0..CLK_DIV-1 on clk_sys.
  - On reaching CLK_DIV-1 it wraps to 0 and toggles i2s_bclk.
  - A 0->1 toggle is a rising edge; no other action.
  - A 1->0 toggle is a falling edge, called a "tick".
- **Slots**:
  - On each tick, slot advances modulo 32 (31 wraps to 0).
  - The first tick after reset enters slot 0, i.e. 2*CLK_DIV cycles after reset release.
- **Outputs**, registered and updated only on ticks, for the slot being entered:
  - i2s_ws = 1 for slot 15..30; 0 for slot 31 and slot 0..14. WS therefore leads the channel MSB by one BCLK.
  - i2s_data = shift register MSB. Left bits occupy slots 0..15 (bit 15 first); right bits occupy slots 16..31.
- **Frame load** (tick entering slot 0):
  - If the buffer is full: shift register <= {buf_l, buf_r} and the buffer is emptied.
  - If the buffer is empty: shift register <= 0, underrun=1 for exactly one clk_sys cycle, and the frame transmits silence.
  - Other ticks shift the register left by 1, filling with 0.
  - i2s_data in slot 0 is the new frame's MSB; the load and the output update happen in the same cycle.
- **Handshake**:
  - sample_ready = ~buffer_full, driven from a register.
  - Accept (valid & ready): buf_l/buf_r captured and full=1 the next cycle.
  - sample_valid while ready=0 has no effect; the source must hold its data.
- **Simultaneous events**:
  - Accept in the same cycle as a frame load with an empty buffer: the load sees empty (underrun pulse, silent frame), and the accepted pair is used at the next frame.
  - Frame load with a full buffer: the buffer empties, and ready=1 the next cycle. An accept is impossible that cycle because ready=0.
- **Throughput**: one pair per 64*CLK_DIV clk_sys cycles. At most one pair is buffered ahead of the pair being transmitted.

Test Plan:
1. **Single pair**: CLK_DIV=2, RESET then present L=16'hA5A5, R=16'h1234.
   - ready drops 1 cycle after accept.
   - First tick at cycle 4; frame bits sampled on BCLK rises = A5A5 then 1234, MSB first.
   - WS=1 from slot 15 to slot 30.
   - ready returns high the cycle after slot-0 load.
2. **Underrun**: CLK_DIV=2, no valid after reset.
   - underrun pulses at the first tick and every 128 cycles thereafter.
   - i2s_data stays 0; BCLK/WS continue toggling.
3. **Back-to-back**: source keeps valid high with counting pairs (L=n, R=~n).
   - One accept per 128 cycles.
   - Decoded stream n=0,1,2,… with no gaps or repeats; underrun only at the first frame if the first accept arrives late.
4. **Simultaneous accept/load**: assert valid exactly in the slot-0 load cycle with the buffer empty.
   - underrun=1 and that frame is zeros.
   - The next frame carries the pair.
5. **Reset mid-frame**: RESET at slot 20.
   - Next cycle: bclk=0, ws=0, data=0, ready=1.
   - After release, the first tick is at slot 0, 2*CLK_DIV cycles later.
6. **Loopback**: feed i2s_bclk/ws/data into the existing I2S receiver with CLK_DIV=8.
   - Receiver left/right outputs equal the transmitted pairs, e.g. L=16'h7FFF, R=16'h8000.
